fc_argmax_axis: RTL and testbench
=================================

Name: fc_argmax_axis

Overview:
Downstream stage of the AXI FC controller. Captures the flat fc_out result vector when fc_fin_valid is high and scans the OUT_LAYER_WIDTH scores sequentially, one per cycle. Presents the winning class index and score as one 32-bit word on an AXI4-Stream master port, for the DMA/PS readback path.

Parameters:
- DATA_WIDTH, 4, bits per score element. Legal range 1..16.
- OUT_LAYER_WIDTH, 4, number of score elements. Legal range 1..65535.

Ports:
- axi_clk  in  1  sole clock.
- axi_reset_n  in  1  reset, asynchronous assert, active-low.
- fc_fin_valid  in  1  one-cycle strobe; fc_out is valid in the same cycle.
- fc_out  in  DATA_WIDTH*OUT_LAYER_WIDTH  score vector; element i = fc_out[i*DATA_WIDTH +: DATA_WIDTH].
- m_axis_valid  out  1  result word valid.
- m_axis_data  out  32  result: [15:0] = argmax index, zero-extended; [31:16] = max score, zero-extended.
- m_axis_ready  in  1  downstream ready.
- busy  out  1  high in SCAN or SEND.
- overrun  out  1  sticky; a frame was dropped.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (axi_clk, axi_reset_n).
- Reset values:
  - state = IDLE.
  - m_axis_valid = 0; m_axis_data = 0.
  - busy = 0; overrun = 0.
  - internal count, best index, best value and captured vector all 0.
  - Reset asserted mid-SCAN or mid-SEND abandons the frame immediately; no partial result is emitted.
- FSM states: IDLE, SCAN, SEND.
- Capture: accepted when fc_fin_valid=1 in IDLE, or in SEND in the same cycle as the output handshake.
  - At the capture edge: latch the whole vector; best_val <= element0; best_idx <= 0; cnt <= 1.
  - Next state = SCAN, or SEND directly if OUT_LAYER_WIDTH == 1.
- SCAN: each edge compares element[cnt] against best_val.
  - Replace best only if element[cnt] > best_val (strict). Ties keep the lower index.
  - cnt increments each edge; when the compared index is OUT_LAYER_WIDTH-1, next state = SEND.
- Latency: m_axis_valid rises OUT_LAYER_WIDTH-1 cycles after the capture edge (3 cycles at defaults; 0 extra cycles when N=1).
- SEND:
  - m_axis_valid = 1; m_axis_data is driven from the best registers.
  - Data stays stable while valid=1 and ready=0.
  - On valid && ready: go to IDLE, or capture a new frame if fc_fin_valid is high in that cycle.
- Comparison is unsigned by default. The score field is zero-extended into [31:16]; bits above the index width in [15:0] are 0.
- Overrun: fc_fin_valid in SCAN, or in SEND without a handshake, drops that frame and sets overrun=1. overrun clears only on reset. The in-flight frame is unaffected.
- fc_fin_valid held high for multiple cycles is treated as repeated strobes.
- busy = (state != IDLE).

Optional Feature:
- Macro: FC_ARGMAX_SIGNED_EN.
- Defined:
  - Scores are two's complement and the comparison is signed.
  - The score field [31:16] is sign-extended.
- Undefined: unsigned comparison, zero-extended score field.
- Tie-break, latency and handshake are identical in both modes.

Decomposition:
- Shared package fc_pkg holds:
  - FSM state encoding (IDLE/SCAN/SEND).
  - Result field constants: RES_IDX_LSB=0, RES_IDX_W=16, RES_VAL_LSB=16, RES_VAL_W=16.
  - AXIS_DATA_W=32.
- One sub-module, fc_argmax_cmp: combinational DATA_WIDTH-bit greater-than, signed or unsigned per FC_ARGMAX_SIGNED_EN. Instantiated once in the datapath.

Test Plan:
- Basic argmax: defaults, fc_out=16'h2931 (elements 1,3,9,2), strobe for one cycle, ready=1 → m_axis_valid rises 3 cycles after capture edge; m_axis_data=32'h0009_0002; one beat only.
- Tie-break: fc_out=16'h5155 (elements 5,5,1,5) → m_axis_data=32'h0005_0000.
- Backpressure then back-to-back: ready=0 for 5 cycles after valid → data held stable and valid held high. Raise ready together with a new strobe (fc_out=16'h0700) → first word accepted, second frame captured, next word=32'h0007_0002.
- Overrun: second strobe one cycle into SCAN → first frame's result is unchanged; overrun=1 and stays 1; no extra output beat.
- Reset mid-scan: drop axi_reset_n during SCAN → all outputs 0 immediately; after release a fresh frame produces a correct result.
- Signed build: FC_ARGMAX_SIGNED_EN defined, fc_out=16'h2931 → 9 is read as -7, so m_axis_data=32'h0003_0001.

Source files
------------

// File: rtl/fc_pkg.sv
// Shared definitions for the FC argmax output stage.
//   - FSM state encoding (IDLE / SCAN / SEND)
//   - Result word layout on the AXI4-Stream port: [15:0] index, [31:16] score
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    SEND = 2'd2
  } fc_state_e;

  localparam int AXIS_DATA_W = 32;
  localparam int RES_IDX_LSB = 0;
  localparam int RES_IDX_W   = 16;
  localparam int RES_VAL_LSB = 16;
  localparam int RES_VAL_W   = 16;

  // Packed so that val lands in [31:16] and idx in [15:0].
  typedef struct packed {
    logic [RES_VAL_W-1:0] val;
    logic [RES_IDX_W-1:0] idx;
  } fc_res_t;

endpackage

// File: rtl/fc_argmax_cmp.sv
// Combinational DATA_WIDTH-bit greater-than used by the argmax scan.
// Macro FC_ARGMAX_SIGNED_EN selects two's-complement comparison;
// otherwise operands are unsigned.
// Ports:
//   a, b : operands
//   gt   : 1 when a > b
module fc_argmax_cmp #(
  parameter int DATA_WIDTH = 4
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  gt
);

`ifdef FC_ARGMAX_SIGNED_EN
  assign gt = $signed(a) > $signed(b);
`else
  assign gt = a > b;
`endif

endmodule

// File: rtl/fc_argmax_axis.sv
// FC argmax output stage. Captures the flat score vector on fc_fin_valid,
// scans one element per cycle for the maximum (ties keep the lower index),
// then presents {score, index} as a single AXI4-Stream beat.
// Macro FC_ARGMAX_SIGNED_EN: signed scores, sign-extended score field.
// Ports:
//   axi_clk, axi_reset_n : clock, async active-low reset
//   fc_fin_valid, fc_out : result strobe and score vector
//   m_axis_valid/data/ready : AXI4-Stream master
//   busy    : state != IDLE
//   overrun : sticky, a frame arrived while one was in flight
module fc_argmax_axis
  import fc_pkg::*;
#(
  parameter int DATA_WIDTH      = 4,
  parameter int OUT_LAYER_WIDTH = 4
) (
  input  logic                                  axi_clk,
  input  logic                                  axi_reset_n,
  input  logic                                  fc_fin_valid,
  input  logic [DATA_WIDTH*OUT_LAYER_WIDTH-1:0] fc_out,
  output logic                                  m_axis_valid,
  output logic [AXIS_DATA_W-1:0]                m_axis_data,
  input  logic                                  m_axis_ready,
  output logic                                  busy,
  output logic                                  overrun
);

  localparam int VEC_W = DATA_WIDTH * OUT_LAYER_WIDTH;
  localparam int IDX_W = (OUT_LAYER_WIDTH > 1) ? $clog2(OUT_LAYER_WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUT_LAYER_WIDTH - 1);

  fc_state_e             state_q, state_d;
  logic [VEC_W-1:0]      vec_q, vec_d;
  logic [IDX_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      best_idx_q, best_idx_d;
  logic [DATA_WIDTH-1:0] best_val_q, best_val_d;
  logic                  valid_q, valid_d;
  fc_res_t               data_q, data_d;
  logic                  overrun_q, overrun_d;

  logic [DATA_WIDTH-1:0] cur_el, el0, scan_val;
  logic [IDX_W-1:0]      scan_idx;
  logic                  gt, hs, capture;

  assign cur_el = vec_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];
  assign el0    = fc_out[DATA_WIDTH-1:0];

  fc_argmax_cmp #(.DATA_WIDTH(DATA_WIDTH)) u_cmp (
    .a  (cur_el),
    .b  (best_val_q),
    .gt (gt)
  );

  // Strict > so an equal later element never displaces the earlier one.
  assign scan_val = gt ? cur_el : best_val_q;
  assign scan_idx = gt ? cnt_q  : best_idx_q;

  assign hs      = valid_q & m_axis_ready;
  assign capture = fc_fin_valid & ((state_q == IDLE) | ((state_q == SEND) & hs));

  function automatic fc_res_t pack_res(input logic [DATA_WIDTH-1:0] v,
                                       input logic [IDX_W-1:0]      i);
    fc_res_t r;
`ifdef FC_ARGMAX_SIGNED_EN
    r.val = RES_VAL_W'($signed(v));
`else
    r.val = RES_VAL_W'(v);
`endif
    r.idx = RES_IDX_W'(i);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    cnt_d      = cnt_q;
    best_idx_d = best_idx_q;
    best_val_d = best_val_q;
    valid_d    = valid_q;
    data_d     = data_q;
    overrun_d  = overrun_q;

    case (state_q)
      IDLE: ;
      SCAN: begin
        best_val_d = scan_val;
        best_idx_d = scan_idx;
        cnt_d      = cnt_q + 1'b1;
        if (cnt_q == LAST_IDX) begin
          state_d = SEND;
          valid_d = 1'b1;
          data_d  = pack_res(scan_val, scan_idx);
        end
        if (fc_fin_valid) overrun_d = 1'b1;
      end
      SEND: begin
        if (hs) begin
          state_d = IDLE;
          valid_d = 1'b0;
        end else if (fc_fin_valid) begin
          overrun_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Capture overrides the IDLE/SEND defaults above; a single-element
    // vector needs no scan and goes straight to SEND.
    if (capture) begin
      vec_d      = fc_out;
      best_val_d = el0;
      best_idx_d = '0;
      cnt_d      = IDX_W'(1);
      if (OUT_LAYER_WIDTH == 1) begin
        state_d = SEND;
        valid_d = 1'b1;
        data_d  = pack_res(el0, '0);
      end else begin
        state_d = SCAN;
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge axi_clk or negedge axi_reset_n) begin
    if (!axi_reset_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      cnt_q      <= '0;
      best_idx_q <= '0;
      best_val_q <= '0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      cnt_q      <= cnt_d;
      best_idx_q <= best_idx_d;
      best_val_q <= best_val_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      overrun_q  <= overrun_d;
    end
  end

  assign m_axis_valid = valid_q;
  assign m_axis_data  = data_q;
  assign busy         = (state_q != IDLE);
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_fc_argmax_axis.sv
module tb_fc_argmax_axis;

  localparam int DW = 4;
  localparam int N  = 4;

  logic          axi_clk = 1'b0;
  logic          axi_reset_n;
  logic          fc_fin_valid;
  logic [DW*N-1:0] fc_out;
  logic          m_axis_valid;
  logic [31:0]   m_axis_data;
  logic          m_axis_ready;
  logic          busy;
  logic          overrun;

  always #5 axi_clk = ~axi_clk;

  fc_argmax_axis #(.DATA_WIDTH(DW), .OUT_LAYER_WIDTH(N)) dut (
    .axi_clk      (axi_clk),
    .axi_reset_n  (axi_reset_n),
    .fc_fin_valid (fc_fin_valid),
    .fc_out       (fc_out),
    .m_axis_valid (m_axis_valid),
    .m_axis_data  (m_axis_data),
    .m_axis_ready (m_axis_ready),
    .busy         (busy),
    .overrun      (overrun)
  );

  int checks = 0;
  int errors = 0;
  int beats  = 0;
  int frames = 0;
  logic [31:0] sb[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard: every accepted beat must match the oldest pushed result.
  always @(negedge axi_clk) begin
    if (axi_reset_n && m_axis_valid && m_axis_ready) begin
      beats++;
      if (sb.size() == 0) begin
        check("extra_beat", m_axis_data, 32'hDEAD_BEEF);
      end else begin
        check("beat_data", m_axis_data, sb.pop_front());
      end
    end
  end

  typedef struct {
    logic [15:0] vec;
    logic [31:0] exp_u;
    logic [31:0] exp_s;
  } vec_t;

  vec_t tbl[8];

  function automatic logic [31:0] pick(input vec_t v);
`ifdef FC_ARGMAX_SIGNED_EN
    return v.exp_s;
`else
    return v.exp_u;
`endif
  endfunction

  task automatic wait_valid(input int maxc, input string nm);
    int n = 0;
    while (!m_axis_valid && n < maxc) begin
      @(negedge axi_clk);
      n++;
    end
    check(nm, {31'd0, m_axis_valid}, 32'd1);
  endtask

  // Single frame with ready held high; checks exact latency.
  task automatic run_frame(input logic [15:0] vec, input logic [31:0] exp);
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b1;
    fc_out       = vec;
    sb.push_back(exp);
    frames++;
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b0;
    for (int k = 0; k < N - 1; k++) begin
      @(negedge axi_clk);
      check("lat_lo", {31'd0, m_axis_valid}, 32'd0);
    end
    @(negedge axi_clk);
    check("lat_hi", {31'd0, m_axis_valid}, 32'd1);
    @(negedge axi_clk);
    check("one_beat", {31'd0, m_axis_valid}, 32'd0);
  endtask

  initial begin
    tbl[0] = '{16'h2931, 32'h0009_0002, 32'h0003_0001};
    tbl[1] = '{16'h5155, 32'h0005_0000, 32'h0005_0000};
    tbl[2] = '{16'h0700, 32'h0007_0002, 32'h0007_0002};
    tbl[3] = '{16'hFFFF, 32'h000F_0000, 32'hFFFF_0000};
    tbl[4] = '{16'h8000, 32'h0008_0003, 32'h0000_0000};
    tbl[5] = '{16'h0000, 32'h0000_0000, 32'h0000_0000};
    tbl[6] = '{16'h1234, 32'h0004_0000, 32'h0004_0000};
    tbl[7] = '{16'h7F00, 32'h000F_0002, 32'h0007_0003};

    axi_reset_n  = 1'b0;
    fc_fin_valid = 1'b0;
    fc_out       = '0;
    m_axis_ready = 1'b1;
    repeat (3) @(negedge axi_clk);
    check("rst_valid",   {31'd0, m_axis_valid}, 32'd0);
    check("rst_data",    m_axis_data, 32'd0);
    check("rst_busy",    {31'd0, busy}, 32'd0);
    check("rst_overrun", {31'd0, overrun}, 32'd0);
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;

    for (int i = 0; i < 8; i++) run_frame(tbl[i].vec, pick(tbl[i]));
    check("ovr_table", {31'd0, overrun}, 32'd0);

    // Backpressure, then accept + new capture in the same cycle.
    @(posedge axi_clk); #1;
    m_axis_ready = 1'b0;
    fc_fin_valid = 1'b1;
    fc_out       = tbl[0].vec;
    sb.push_back(pick(tbl[0]));
    frames++;
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b0;
    @(negedge axi_clk);
    wait_valid(10, "bp_valid");
    for (int k = 0; k < 5; k++) begin
      @(negedge axi_clk);
      check("bp_hold_v", {31'd0, m_axis_valid}, 32'd1);
      check("bp_hold_d", m_axis_data, pick(tbl[0]));
    end
    @(posedge axi_clk); #1;
    m_axis_ready = 1'b1;
    fc_fin_valid = 1'b1;
    fc_out       = 16'h0700;
    sb.push_back(pick(tbl[2]));
    frames++;
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b0;
    @(negedge axi_clk);
    check("b2b_busy",  {31'd0, busy}, 32'd1);
    check("b2b_valid", {31'd0, m_axis_valid}, 32'd0);
    wait_valid(10, "b2b_valid2");
    @(negedge axi_clk);
    check("b2b_ovr", {31'd0, overrun}, 32'd0);

    // Overrun: second strobe one cycle into SCAN is dropped.
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b1;
    fc_out       = 16'h1234;
    sb.push_back(pick(tbl[6]));
    frames++;
    @(posedge axi_clk); #1;
    fc_out = 16'hFFFF;
    @(negedge axi_clk);
    check("ovr_pre", {31'd0, overrun}, 32'd0);
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b0;
    @(negedge axi_clk);
    check("ovr_set", {31'd0, overrun}, 32'd1);
    wait_valid(10, "ovr_valid");
    repeat (8) @(negedge axi_clk);
    check("ovr_sticky", {31'd0, overrun}, 32'd1);
    check("ovr_idle",   {31'd0, busy}, 32'd0);

    // Reset during SCAN abandons the frame.
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b1;
    fc_out       = 16'h2931;
    @(posedge axi_clk); #1;
    fc_fin_valid = 1'b0;
    @(posedge axi_clk); #3;
    check("mid_busy_pre", {31'd0, busy}, 32'd1);
    axi_reset_n = 1'b0;
    #1;
    check("mid_valid",   {31'd0, m_axis_valid}, 32'd0);
    check("mid_data",    m_axis_data, 32'd0);
    check("mid_busy",    {31'd0, busy}, 32'd0);
    check("mid_overrun", {31'd0, overrun}, 32'd0);
    @(posedge axi_clk); #1;
    axi_reset_n = 1'b1;
    repeat (6) @(negedge axi_clk);
    check("mid_no_beat", {31'd0, m_axis_valid}, 32'd0);
    run_frame(tbl[7].vec, pick(tbl[7]));

    repeat (4) @(negedge axi_clk);
    check("sb_empty", sb.size(), 32'd0);
    check("beat_cnt", beats, frames);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
